// File: rtl/issue_ctrl.sv
// Single-entry RV32I decode/issue controller with a 32-entry register scoreboard.
// Optional ISSUE_WB_BYPASS_EN: hazard check sees the current-cycle writeback as already cleared.
module issue_ctrl #(
  parameter int MAX_OUTST = 4,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic [31:0]   dec_instr,
  input  logic [6:0]    dec_type_code,
  input  logic [9:0]    dec_alu_op,
  input  logic [4:0]    dec_rs1,
  input  logic [4:0]    dec_rs2,
  input  logic [4:0]    dec_rd,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [31:0]   iss_instr,
  output logic [9:0]    iss_alu_op,
  output logic [4:0]    iss_rs1,
  output logic [4:0]    iss_rs2,
  output logic [4:0]    iss_rd,
  output logic          iss_we,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  input  logic          flush,
  output logic          illegal,
  input  logic          trap_ack,
  output logic [31:0]   busy_vec,
  output logic [CW-1:0] outstanding
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_TRAP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] outst_q, outst_d;

  logic          supported, use_rs1, use_rs2, writes_rd;
  logic          wb_eff, hazard, fire, inc, dec;
  logic [31:0]   busy_chk, wb_mask, set_mask;
  logic [CW-1:0] outst_chk;

  always_comb begin
    supported = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (dec_type_code)
      7'b0110011: {use_rs1, use_rs2, writes_rd} = 3'b111;
      7'b0010011: {use_rs1, use_rs2, writes_rd} = 3'b101;
      7'b0000011: {use_rs1, use_rs2, writes_rd} = 3'b101;
      7'b0100011: {use_rs1, use_rs2, writes_rd} = 3'b110;
      7'b1100011: {use_rs1, use_rs2, writes_rd} = 3'b110;
      7'b1100111: {use_rs1, use_rs2, writes_rd} = 3'b101;
      7'b1101111: {use_rs1, use_rs2, writes_rd} = 3'b001;
      7'b0110111: {use_rs1, use_rs2, writes_rd} = 3'b001;
      7'b0010111: {use_rs1, use_rs2, writes_rd} = 3'b001;
      default:    supported = 1'b0;
    endcase
  end

  // busy_q[0] is held at 0, so a writeback to x0 never counts as effective.
  assign wb_eff  = wb_valid && busy_q[wb_rd];
  assign wb_mask = wb_eff ? (32'd1 << wb_rd) : 32'd0;
  assign iss_we  = writes_rd && (dec_rd != 5'd0);

  always_comb begin
`ifdef ISSUE_WB_BYPASS_EN
    busy_chk  = busy_q & ~wb_mask;
    outst_chk = outst_q - CW'(wb_eff);
`else
    busy_chk  = busy_q;
    outst_chk = outst_q;
`endif
    hazard = (use_rs1 && busy_chk[dec_rs1]) ||
             (use_rs2 && busy_chk[dec_rs2]) ||
             (iss_we && (busy_chk[dec_rd] || (outst_chk == CW'(MAX_OUTST))));
  end

  assign iss_valid = (state_q == ST_FULL) && supported && !hazard && !flush;
  assign fire      = iss_valid && iss_ready;
  assign in_ready  = (state_q == ST_EMPTY) || fire;
  assign illegal   = (state_q == ST_TRAP);

  assign set_mask = (fire && iss_we) ? (32'd1 << dec_rd) : 32'd0;
  // A set onto a reg still busy (bypass case) keeps the count; its paired clear must not decrement.
  assign inc = fire && iss_we && !busy_q[dec_rd];
  assign dec = wb_eff && !(fire && iss_we && (dec_rd == wb_rd));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    busy_d  = ((busy_q & ~wb_mask) | set_mask) & ~32'd1;
    outst_d = outst_q + CW'(inc) - CW'(dec);
    case (state_q)
      ST_EMPTY: begin
        if (in_valid && !flush) begin
          state_d = ST_FULL;
          instr_d = in_instr;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (!supported) begin
          state_d = ST_TRAP;
        end else if (fire) begin
          if (in_valid) begin
            instr_d = in_instr;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_TRAP: begin
        if (flush || trap_ack) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= 32'd0;
      busy_q  <= 32'd0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      outst_q <= outst_d;
    end
  end

  assign dec_instr   = instr_q;
  assign iss_instr   = instr_q;
  assign iss_alu_op  = dec_alu_op;
  assign iss_rs1     = dec_rs1;
  assign iss_rs2     = dec_rs2;
  assign iss_rd      = dec_rd;
  assign busy_vec    = busy_q;
  assign outstanding = outst_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic against a scoreboard model.
module tb_issue_ctrl;
  localparam int MAX_OUTST = 4;
  localparam int CW        = 3;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] ADD3 = 32'h002081B3;
  localparam logic [31:0] SUB5 = 32'h404182B3;
  localparam logic [31:0] ADD7 = 32'h002083B3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, iss_valid, iss_ready, iss_we;
  logic wb_valid, flush, illegal, trap_ack;
  logic [31:0] in_instr, dec_instr, iss_instr, busy_vec;
  logic [6:0]  dec_type_code;
  logic [9:0]  dec_alu_op, iss_alu_op;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [CW-1:0] outstanding;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational RV32I decoder.
  assign dec_type_code = dec_instr[6:0];
  assign dec_rd        = dec_instr[11:7];
  assign dec_rs1       = dec_instr[19:15];
  assign dec_rs2       = dec_instr[24:20];
  assign dec_alu_op    = {dec_instr[31:25], dec_instr[14:12]};

  issue_ctrl #(.MAX_OUTST(MAX_OUTST), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .dec_instr(dec_instr), .dec_type_code(dec_type_code), .dec_alu_op(dec_alu_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
    .iss_alu_op(iss_alu_op), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_we(iss_we), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .illegal(illegal), .trap_ack(trap_ack), .busy_vec(busy_vec), .outstanding(outstanding)
  );

  function automatic logic [31:0] addi(input int rd);
    logic [4:0] r;
    r = 5'(rd);
    return {12'd1, 5'd0, 3'b000, r, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; iss_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0; trap_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, iss_valid, illegal} !== 3'b100) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=100", {in_ready, iss_valid, illegal});
    end
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 3'd0) begin
      failures++; $display("FAIL reset_sb got busy=%h outst=%0d exp 0/0", busy_vec, outstanding);
    end
    checks++;
    if (dec_instr !== 32'd0 || iss_we !== 1'b0 || iss_rd !== 5'd0 || iss_alu_op !== 10'd0) begin
      failures++; $display("FAIL reset_fields got instr=%h we=%b rd=%0d", dec_instr, iss_we, iss_rd);
    end
  endtask

  task automatic test_add();
    in_instr = ADD3; in_valid = 1'b1; iss_ready = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if ({iss_valid, iss_we, iss_rd} !== {1'b1, 1'b1, 5'd3}) begin
      failures++; $display("FAIL add_issue got v=%b we=%b rd=%0d exp v=1 we=1 rd=3", iss_valid, iss_we, iss_rd);
    end
    checks++;
    if (iss_instr !== ADD3 || iss_rs1 !== 5'd1 || iss_rs2 !== 5'd2) begin
      failures++; $display("FAIL add_fields got instr=%h rs1=%0d rs2=%0d", iss_instr, iss_rs1, iss_rs2);
    end
    tick(); #1;
    checks++;
    if (busy_vec !== 32'h8 || outstanding !== 3'd1 || iss_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL add_sb got busy=%h outst=%0d v=%b rdy=%b exp 8/1/0/1", busy_vec, outstanding, iss_valid, in_ready);
    end
  endtask

  task automatic test_raw();
    in_instr = SUB5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL raw_stall0 got=%b exp=0", iss_valid); end
    tick(); #1;
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL raw_stall1 got=%b exp=0", iss_valid); end
    wb_valid = 1'b1; wb_rd = 5'd3; #1;
    checks++;
    if (iss_valid !== BYP) begin failures++; $display("FAIL raw_wb_cycle got=%b exp=%b", iss_valid, BYP); end
    tick();
    wb_valid = 1'b0; #1;
    if (!BYP) begin
      checks++;
      if (iss_valid !== 1'b1 || busy_vec !== 32'd0) begin
        failures++; $display("FAIL raw_after_wb got v=%b busy=%h exp v=1 busy=0", iss_valid, busy_vec);
      end
      tick(); #1;
    end
    checks++;
    if (busy_vec !== 32'h20 || outstanding !== 3'd1) begin
      failures++; $display("FAIL raw_sb got busy=%h outst=%0d exp 20/1", busy_vec, outstanding);
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    tick();
    wb_valid = 1'b0; #1;
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 3'd0) begin
      failures++; $display("FAIL raw_clean got busy=%h outst=%0d exp 0/0", busy_vec, outstanding);
    end
  endtask

  task automatic test_max_outst();
    for (int k = 1; k <= 5; k++) begin
      in_instr = addi(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd4 || busy_vec !== 32'h1E || iss_valid !== 1'b0 || iss_rd !== 5'd5) begin
      failures++; $display("FAIL max_stall got outst=%0d busy=%h v=%b rd=%0d", outstanding, busy_vec, iss_valid, iss_rd);
    end
    tick(); #1;
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL max_hold got=%b exp=0", iss_valid); end
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    checks++;
    if (iss_valid !== BYP) begin failures++; $display("FAIL max_wb_cycle got=%b exp=%b", iss_valid, BYP); end
    tick();
    wb_valid = 1'b0; #1;
    if (!BYP) begin
      checks++;
      if (iss_valid !== 1'b1 || outstanding !== 3'd3) begin
        failures++; $display("FAIL max_after_wb got v=%b outst=%0d exp 1/3", iss_valid, outstanding);
      end
      tick(); #1;
    end
    checks++;
    if (busy_vec !== 32'h3C || outstanding !== 3'd4) begin
      failures++; $display("FAIL max_sb got busy=%h outst=%0d exp 3c/4", busy_vec, outstanding);
    end
    for (int k = 2; k <= 5; k++) begin
      wb_valid = 1'b1; wb_rd = 5'(k);
      tick();
    end
    wb_valid = 1'b0; #1;
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 3'd0) begin
      failures++; $display("FAIL max_clean got busy=%h outst=%0d exp 0/0", busy_vec, outstanding);
    end
  endtask

  task automatic test_illegal();
    in_instr = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if ({iss_valid, in_ready} !== 2'b00) begin
      failures++; $display("FAIL ill_full got v=%b rdy=%b exp 0/0", iss_valid, in_ready);
    end
    tick(); #1;
    checks++;
    if ({illegal, in_ready, iss_valid} !== 3'b100) begin
      failures++; $display("FAIL ill_trap got=%b exp=100", {illegal, in_ready, iss_valid});
    end
    tick(); #1;
    checks++;
    if (illegal !== 1'b1) begin failures++; $display("FAIL ill_hold got=%b exp=1", illegal); end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0; #1;
    checks++;
    if ({illegal, in_ready, outstanding} !== {2'b01, 3'd0}) begin
      failures++; $display("FAIL ill_ack got ill=%b rdy=%b outst=%0d exp 0/1/0", illegal, in_ready, outstanding);
    end
  endtask

  task automatic test_flush();
    in_instr = addi(1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_instr = ADD7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (iss_valid !== 1'b0 || busy_vec !== 32'h2) begin
      failures++; $display("FAIL flush_pre got v=%b busy=%h exp 0/2", iss_valid, busy_vec);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || busy_vec !== 32'h2 || outstanding !== 3'd1) begin
      failures++; $display("FAIL flush_empty got rdy=%b busy=%h outst=%0d exp 1/2/1", in_ready, busy_vec, outstanding);
    end
    tick(); #1;
    checks++;
    if (iss_valid !== 1'b0 || busy_vec !== 32'h2) begin
      failures++; $display("FAIL flush_noissue got v=%b busy=%h exp 0/2", iss_valid, busy_vec);
    end
    in_instr = addi(9); in_valid = 1'b1; flush = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_drop_rdy got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; flush = 1'b0; #1;
    checks++;
    if ({iss_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_dropped got v=%b rdy=%b exp 0/1", iss_valid, in_ready);
    end
  endtask

  task automatic test_same_edge();
    in_instr = addi(6); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; #1;
    checks++;
    if (iss_valid !== 1'b1) begin failures++; $display("FAIL same_fire got=%b exp=1", iss_valid); end
    tick();
    wb_valid = 1'b0; #1;
    checks++;
    if (busy_vec !== 32'h42 || outstanding !== 3'd2) begin
      failures++; $display("FAIL same_set got busy=%h outst=%0d exp 42/2", busy_vec, outstanding);
    end
    in_instr = addi(6); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; #1;
    checks++;
    if (iss_valid !== BYP) begin failures++; $display("FAIL same_busy_cycle got=%b exp=%b", iss_valid, BYP); end
    tick();
    wb_valid = 1'b0; #1;
    if (!BYP) begin
      checks++;
      if (iss_valid !== 1'b1 || busy_vec !== 32'h2) begin
        failures++; $display("FAIL same_after_wb got v=%b busy=%h exp 1/2", iss_valid, busy_vec);
      end
      tick(); #1;
    end
    checks++;
    if (busy_vec !== 32'h42 || outstanding !== 3'd2) begin
      failures++; $display("FAIL same_wins got busy=%h outst=%0d exp 42/2", busy_vec, outstanding);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 3'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL async_rst got busy=%h outst=%0d rdy=%b", busy_vec, outstanding, in_ready);
    end
    do_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Model: mst 0=empty 1=holding 2=trapped; scoreboard as a bit set, count = set size.
  task automatic test_random();
    int mst;
    logic [31:0] mheld, mbusy, eb;
    int ecnt;
    logic sup, u1, u2, wr, we, haz, ev, er, fire;
    logic [4:0] rd, r1, r2;
    do_reset();
    mst = 0; mheld = 32'd0; mbusy = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      iss_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_rd     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      trap_ack  = ($urandom_range(0, 9) < 3);
      #1;
      sup = 1'b1; u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
      case (mheld[6:0])
        7'b0110011:                          begin u1 = 1; u2 = 1; wr = 1; end
        7'b0010011, 7'b0000011, 7'b1100111:  begin u1 = 1; wr = 1; end
        7'b0100011, 7'b1100011:              begin u1 = 1; u2 = 1; end
        7'b1101111, 7'b0110111, 7'b0010111:  wr = 1;
        default:                             sup = 1'b0;
      endcase
      rd = mheld[11:7]; r1 = mheld[19:15]; r2 = mheld[24:20];
      we = wr && (rd != 0);
      eb = mbusy; ecnt = $countones(mbusy);
      if (BYP && wb_valid && mbusy[wb_rd]) begin eb[wb_rd] = 1'b0; ecnt--; end
      haz = (u1 && eb[r1]) || (u2 && eb[r2]) || (we && (eb[rd] || ecnt == MAX_OUTST));
      ev = (mst == 1) && sup && !haz && !flush;
      fire = ev && iss_ready;
      er = (mst == 0) || fire;
      checks++;
      if ({iss_valid, in_ready, illegal} !== {ev, er, mst == 2}) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got v/rdy/ill=%b exp=%b", cyc, {iss_valid, in_ready, illegal}, {ev, er, mst == 2});
      end
      checks++;
      if (busy_vec !== mbusy || outstanding !== CW'($countones(mbusy))) begin
        failures++; $display("FAIL rnd_sb cyc=%0d got busy=%h outst=%0d exp busy=%h outst=%0d", cyc, busy_vec, outstanding, mbusy, $countones(mbusy));
      end
      if (mst == 1) begin
        checks++;
        if (iss_instr !== mheld || iss_we !== we || iss_rd !== rd) begin
          failures++; $display("FAIL rnd_fields cyc=%0d got instr=%h we=%b rd=%0d exp instr=%h we=%b rd=%0d", cyc, iss_instr, iss_we, iss_rd, mheld, we, rd);
        end
      end
      if (wb_valid) mbusy[wb_rd] = 1'b0;
      if (fire && we) mbusy[rd] = 1'b1;
      mbusy[0] = 1'b0;
      case (mst)
        0: if (in_valid && !flush) begin mst = 1; mheld = in_instr; end
        1: begin
          if (flush) mst = 0;
          else if (!sup) mst = 2;
          else if (fire) begin
            if (in_valid) mheld = in_instr;
            else mst = 0;
          end
        end
        default: if (flush || trap_ack) mst = 0;
      endcase
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_raw();
    test_max_outst();
    test_illegal();
    test_flush();
    test_same_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Single-entry decode/issue stage controller for the RV32I core.
- Holds one fetched instruction and drives it to the combinational RV32I decoder.
- Uses the decoded opcode and register fields to detect RAW/WAW hazards against a 32-entry register scoreboard.
- Issues the instruction to the execute stage over a valid/ready handshake, and clears scoreboard entries when writebacks return.

Parameters:
MAX_OUTST, 4, maximum number of issued-but-not-written-back register writes (1..31)
CW, 3, width of the outstanding counter; must satisfy 2^CW > MAX_OUTST

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  upstream may transfer this cycle
in_instr  in  32  fetched instruction
dec_instr  out  32  held instruction, driven to the decoder
dec_type_code  in  7  decoder opcode field (instr[6:0])
dec_alu_op  in  10  decoder ALU op code
dec_rs1  in  5  decoder rs1
dec_rs2  in  5  decoder rs2
dec_rd  in  5  decoder rd
iss_valid  out  1  issue valid to execute
iss_ready  in  1  execute accepts
iss_instr  out  32  issued instruction
iss_alu_op  out  10  issued ALU op
iss_rs1  out  5  issued rs1
iss_rs2  out  5  issued rs2
iss_rd  out  5  issued rd
iss_we  out  1  instruction writes rd (rd!=0 and opcode writes)
wb_valid  in  1  writeback completes
wb_rd  in  5  writeback destination
flush  in  1  discard held instruction
illegal  out  1  held instruction has unsupported opcode (TRAP state)
trap_ack  in  1  clears TRAP
busy_vec  out  32  scoreboard, bit i = xi pending
outstanding  out  CW  count of set busy bits

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; held instruction 0; busy_vec 0; outstanding 0; in_ready 1; iss_valid 0; illegal 0. All iss_* fields are 0 while the held register is 0.
- States:
  - EMPTY: in_ready=1. in_valid moves to FULL and latches in_instr.
  - FULL: compute hazard. A fire (iss_valid and iss_ready) leads to one of:
    - with in_valid: reload and stay FULL;
    - without in_valid: go to EMPTY.
    Unsupported opcode goes to TRAP at the next edge without issuing.
  - TRAP: illegal=1, in_ready=0, iss_valid=0. trap_ack goes to EMPTY.
- Opcode use table (uses rs1 / uses rs2 / writes rd):
  - 0110011 R: y/y/y
  - 0010011 I-ALU: y/n/y
  - 0000011 load: y/n/y
  - 0100011 store: y/y/n
  - 1100011 branch: y/y/n
  - 1100111 JALR: y/n/y
  - 1101111 JAL: n/n/y
  - 0110111 LUI: n/n/y
  - 0010111 AUIPC: n/n/y
  - Any other opcode is unsupported.
- iss_we = writes_rd && dec_rd!=0. x0 is never marked busy; busy_vec[0] is always 0.
- Hazard conditions (each stalls), evaluated on registered busy_vec:
  - used source busy;
  - iss_we && busy[rd] (WAW);
  - iss_we && outstanding==MAX_OUTST.
- iss_valid = FULL && !hazard && supported. It is combinational and does not depend on iss_ready.
- in_ready = EMPTY || fire.
  - Throughput is 1 instruction/cycle when hazard-free.
  - Latency is accept at edge N, iss_valid at the earliest in the cycle after edge N.
- Scoreboard update per edge:
  - fire with iss_we sets busy[iss_rd];
  - wb_valid clears busy[wb_rd];
  - if both target the same reg, the set wins.
  - outstanding = popcount-equivalent increment/decrement. Simultaneous set and clear of different regs leaves it unchanged. wb to a non-busy reg or x0 is ignored with no decrement.
- flush (FULL or TRAP): go to EMPTY next edge and suppress fire that cycle (iss_valid forced 0). The scoreboard is untouched. flush in EMPTY with in_valid: the incoming instruction is dropped (in_ready stays 1).
- Reset mid-operation discards the held instruction and the whole scoreboard.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: hazard check uses busy_vec with the current-cycle wb_rd bit cleared. A source or rd written back this cycle does not stall, and the instruction may fire in the same cycle. The outstanding limit check also subtracts a valid, effective writeback.
- Undefined: hazard uses registered busy_vec only. The instruction fires no earlier than the cycle after the writeback.

Test Plan:
- Reset then in_instr=0x002081B3 (add x3,x1,x2), iss_ready=1 -> iss_valid next cycle, iss_rd=3, iss_we=1; busy_vec=0x00000008, outstanding=1.
- Then sub x5,x3,x4 (0x404182B3) -> iss_valid=0 until wb_valid with wb_rd=3. Without bypass, fire is the cycle after wb; with ISSUE_WB_BYPASS_EN, fire is the same cycle.
- MAX_OUTST=4: issue addi to x1..x4 with no wb, then addi x5 -> stalled with outstanding=4. One wb_rd=1 -> addi x5 issues next cycle.
- in_instr=0xFFFFFFFF -> illegal=1, in_ready=0, no fire; trap_ack -> EMPTY, illegal=0.
- Held add x7 stalled on a busy rs1, flush=1 -> EMPTY, busy_vec unchanged, no issue of x7.
- Same-edge fire of addi x6 and wb_rd=6 (x6 previously busy via WAW-free path): after the edge busy[6]=1 (set wins), outstanding unchanged.
